// File: rtl/cache_ctrl.sv
// CPU-side controller for a 128-entry direct-mapped, write-through / write-allocate cache.
// Misses and writes go to backing memory through a req/ack handshake that times out after MAX_WAIT cycles.
module cache_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [15:0] cache_addr,
  output logic        cache_w_rd,
  output logic [7:0]  cache_wdata,
  input  logic [7:0]  cache_rdata,
  input  logic        cache_hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    FILL   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] wait_r, wait_s;
  logic [15:0]   addr_r, hit_r, miss_r;
  logic          we_r, ready_r, err_r, w_rd_r, req_r, mem_we_r;
  logic [7:0]    wdata_r, rdata_r, fill_r;
  logic          hit_inc_s, miss_inc_s, ack_s;

  // Next-state, wait-counter and event decode.
  always_comb begin
    state_s    = state_r;
    wait_s     = wait_r;
    hit_inc_s  = 1'b0;
    miss_inc_s = 1'b0;
    ack_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req) begin
          state_s = cpu_we ? MEM_WR : LOOKUP;
          wait_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      LOOKUP: begin
        if (cache_hit) begin
          state_s   = DONE;
          hit_inc_s = 1'b1;
        end else begin
          state_s    = MEM_RD;
          miss_inc_s = 1'b1;
          wait_s     = '0;
        end
      end
      MEM_RD, MEM_WR: begin
        // An ack arriving in the final allowed cycle still counts as success.
        if (mem_ack) begin
          state_s = FILL;
          ack_s   = 1'b1;
        end else if (wait_r == CW'(MAX_WAIT)) begin
          state_s = ERR;
        end else begin
          wait_s = wait_r + CW'(1);
        end
      end
      FILL:    state_s = DONE;
      DONE:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, request latch, statistics and registered outputs.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      wait_r   <= '0;
      addr_r   <= 16'h0000;
      we_r     <= 1'b0;
      wdata_r  <= 8'h00;
      rdata_r  <= 8'h00;
      fill_r   <= 8'h00;
      hit_r    <= 16'h0000;
      miss_r   <= 16'h0000;
      ready_r  <= 1'b0;
      err_r    <= 1'b0;
      w_rd_r   <= 1'b0;
      req_r    <= 1'b0;
      mem_we_r <= 1'b0;
    end else begin
      state_r <= state_s;
      wait_r  <= wait_s;
      if (state_r == IDLE && cpu_req) begin
        addr_r  <= cpu_addr;
        we_r    <= cpu_we;
        wdata_r <= cpu_wdata;
      end
      if (hit_inc_s) begin
        rdata_r <= cache_rdata;
        if (hit_r != 16'hFFFF) hit_r <= hit_r + 16'd1;
      end
      if (miss_inc_s && miss_r != 16'hFFFF) miss_r <= miss_r + 16'd1;
      if (ack_s) begin
        fill_r <= we_r ? wdata_r : mem_rdata;
        if (!we_r) rdata_r <= mem_rdata;
      end
      ready_r  <= (state_s == DONE) || (state_s == ERR);
      err_r    <= (state_s == ERR);
      w_rd_r   <= (state_s == FILL);
      req_r    <= (state_s == MEM_RD) || (state_s == MEM_WR);
      mem_we_r <= (state_s == MEM_WR);
    end
  end

  assign cpu_rdata   = rdata_r;
  assign cpu_ready   = ready_r;
  assign cpu_err     = err_r;
  assign cache_addr  = addr_r;
  assign cache_w_rd  = w_rd_r;
  assign cache_wdata = fill_r;
  assign mem_req     = req_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = addr_r;
  assign mem_wdata   = wdata_r;
  assign hit_cnt     = hit_r;
  assign miss_cnt    = miss_r;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed vector table, multi-cycle corner sequences,
// and random accesses checked against a transaction-level model.
module tb_cache_ctrl;
  localparam int MAX_WAIT = 15;

  logic        clk_1 = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic [15:0] cache_addr;
  logic        cache_w_rd;
  logic [7:0]  cache_wdata, cache_rdata;
  logic        cache_hit;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt, miss_cnt;

  cache_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_1(clk_1), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .cache_addr(cache_addr), .cache_w_rd(cache_w_rd), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk_1 = ~clk_1;

  typedef struct {
    int          lat;
    logic        err;
    logic [7:0]  rdata;
    int          reqs;
    int          fills;
    logic [7:0]  fdata;
    logic [15:0] hc;
    logic [15:0] mc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        hit;
    logic [7:0]  crd;
    int          w;
    logic [7:0]  mrd;
    exp_t        e;
  } vec_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [7:0]  rdata;
    int          reqs;
    int          fills;
    logic [7:0]  fdata;
    logic [15:0] faddr;
    int          rlen;
    logic        bad_mem;
    logic        bad_look;
    logic        overlap;
  } obs_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  m_rdata;
  logic [15:0] m_hc, m_mc;
  vec_t        vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: latency = lookup + memory phase + (fill+done | err).
  task automatic model(input logic we, input logic hit, input logic [7:0] wd, input logic [7:0] crd,
                       input logic [7:0] mrd, input int w, output exp_t e);
    bit tmo;
    int m;
    tmo     = (w < 0) || (w > MAX_WAIT);
    e.err   = 1'b0;
    e.fdata = 8'h00;
    if (!we && hit) begin
      e.lat = 2; e.reqs = 0; e.fills = 0;
      m_rdata = crd;
      if (m_hc != 16'hFFFF) m_hc = m_hc + 16'd1;
    end else begin
      if (!we && m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
      m       = tmo ? MAX_WAIT + 1 : w + 1;
      e.lat   = (we ? 0 : 1) + m + (tmo ? 1 : 2);
      e.reqs  = m;
      e.fills = tmo ? 0 : 1;
      e.fdata = we ? wd : mrd;
      e.err   = tmo;
      if (!we && !tmo) m_rdata = mrd;
    end
    e.rdata = m_rdata; e.hc = m_hc; e.mc = m_mc;
  endtask

  // Drives one CPU access and plays memory; returns what was seen on the pins.
  task automatic run_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                            input logic hit, input logic [7:0] crd, input int w,
                            input logic [7:0] mrd, input logic noise, output obs_t o);
    o.lat = -1; o.err = 1'b0; o.rdata = 8'h00; o.reqs = 0; o.fills = 0; o.fdata = 8'h00;
    o.faddr = 16'h0000; o.rlen = 0; o.bad_mem = 1'b0; o.bad_look = 1'b0; o.overlap = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    cache_hit = hit; cache_rdata = crd; mem_rdata = mrd; mem_ack = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_1);
      if (k == 1) begin
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
        if (!we && (cache_addr !== addr || cache_w_rd !== 1'b0)) o.bad_look = 1'b1;
      end
      if (mem_req) begin
        o.reqs++;
        if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wd)) o.bad_mem = 1'b1;
      end
      if (cache_w_rd) begin
        o.fills++; o.fdata = cache_wdata; o.faddr = cache_addr;
      end
      if (mem_req && (cache_w_rd || cpu_ready)) o.overlap = 1'b1;
      if (cpu_ready) begin
        if (o.lat < 0) begin
          o.lat = k; o.err = cpu_err; o.rdata = cpu_rdata;
        end
        o.rlen++;
      end else if (o.lat >= 0) begin
        break;
      end
      mem_ack = mem_req ? (w >= 0 && o.reqs == w + 1) : (noise ? 1'($urandom) : 1'b0);
    end
    mem_ack = 1'b0;
  endtask

  task automatic verify(input string t, input obs_t o, input exp_t e, input logic [15:0] addr);
    chk({t, ".latency"}, 32'(o.lat), 32'(e.lat));
    chk({t, ".cpu_err"}, 32'(o.err), 32'(e.err));
    chk({t, ".cpu_rdata"}, 32'(o.rdata), 32'(e.rdata));
    chk({t, ".mem_req_cycles"}, 32'(o.reqs), 32'(e.reqs));
    chk({t, ".fill_pulses"}, 32'(o.fills), 32'(e.fills));
    if (e.fills > 0) begin
      chk({t, ".fill_data"}, 32'(o.fdata), 32'(e.fdata));
      chk({t, ".fill_addr"}, 32'(o.faddr), 32'(addr));
    end
    chk({t, ".ready_width"}, 32'(o.rlen), 32'd1);
    chk({t, ".mem_port_bad"}, 32'(o.bad_mem), 32'd0);
    chk({t, ".lookup_bad"}, 32'(o.bad_look), 32'd0);
    chk({t, ".req_overlap"}, 32'(o.overlap), 32'd0);
    chk({t, ".hit_cnt"}, 32'(hit_cnt), 32'(e.hc));
    chk({t, ".miss_cnt"}, 32'(miss_cnt), 32'(e.mc));
  endtask

  initial begin
    obs_t o;
    exp_t e;
    int   mask, w_rd_seen, rdy_seen;
    logic we, hit;
    logic [15:0] addr;
    logic [7:0] wd, crd, mrd;
    int   w;

    // inputs: we, addr, wd, hit, crd, w (-1 = never), mrd; expected: lat, err, rdata, reqs, fills, fdata, hc, mc
    vt[0] = '{1'b0, 16'h1234, 8'h00, 1'b0, 8'h00,  2, 8'hA5, '{ 6, 1'b0, 8'hA5,  3, 1, 8'hA5, 16'd0, 16'd1}};
    vt[1] = '{1'b0, 16'h1234, 8'h00, 1'b1, 8'hA5,  0, 8'h00, '{ 2, 1'b0, 8'hA5,  0, 0, 8'h00, 16'd1, 16'd1}};
    vt[2] = '{1'b1, 16'h0080, 8'h3C, 1'b0, 8'h00,  0, 8'h00, '{ 3, 1'b0, 8'hA5,  1, 1, 8'h3C, 16'd1, 16'd1}};
    vt[3] = '{1'b0, 16'h0100, 8'h00, 1'b0, 8'h00, -1, 8'h99, '{18, 1'b1, 8'hA5, 16, 0, 8'h00, 16'd1, 16'd2}};
    vt[4] = '{1'b0, 16'h0200, 8'h00, 1'b0, 8'h00, 15, 8'h5A, '{19, 1'b0, 8'h5A, 16, 1, 8'h5A, 16'd1, 16'd3}};
    vt[5] = '{1'b1, 16'h0300, 8'h77, 1'b0, 8'h00, -1, 8'h00, '{17, 1'b1, 8'h5A, 16, 0, 8'h00, 16'd1, 16'd3}};
    vt[6] = '{1'b0, 16'hFFFF, 8'h00, 1'b1, 8'hC3,  0, 8'h00, '{ 2, 1'b0, 8'hC3,  0, 0, 8'h00, 16'd2, 16'd3}};
    vt[7] = '{1'b1, 16'hFFFF, 8'h11, 1'b0, 8'h00, 15, 8'h00, '{18, 1'b0, 8'hC3, 16, 1, 8'h11, 16'd2, 16'd3}};
    vt[8] = '{1'b0, 16'h007F, 8'h00, 1'b0, 8'h00, 14, 8'h00, '{18, 1'b0, 8'h00, 15, 1, 8'h00, 16'd2, 16'd4}};

    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    cache_rdata = 8'h00; cache_hit = 1'b0; mem_rdata = 8'h00; mem_ack = 1'b0;
    m_rdata = 8'h00; m_hc = 16'h0000; m_mc = 16'h0000;

    // Reset values, before and after clock edges with reset held, and just after release.
    #1;
    chk("rst.cpu", 32'({cpu_rdata, cpu_ready, cpu_err}), 32'd0);
    chk("rst.cache", 32'({cache_addr, cache_w_rd, cache_wdata}), 32'd0);
    chk("rst.mem", 32'({mem_req, mem_we, mem_wdata}), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    chk("rst.counts", {hit_cnt, miss_cnt}, 32'd0);
    cpu_req = 1'b1; mem_ack = 1'b1;
    repeat (2) @(negedge clk_1);
    chk("rst_held.outs", 32'({cpu_ready, cache_w_rd, mem_req, cache_addr}), 32'd0);
    cpu_req = 1'b0; mem_ack = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_release.outs", 32'({cpu_ready, cpu_err, mem_req, cache_addr}), 32'd0);
    @(negedge clk_1);

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      model(vt[i].we, vt[i].hit, vt[i].wd, vt[i].crd, vt[i].mrd, vt[i].w, e);
      run_access(vt[i].we, vt[i].addr, vt[i].wd, vt[i].hit, vt[i].crd, vt[i].w, vt[i].mrd, 1'b0, o);
      verify($sformatf("vec%0d", i), o, vt[i].e, vt[i].addr);
    end

    // cpu_req held through DONE: second acceptance only from IDLE afterwards.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042; cache_hit = 1'b1; cache_rdata = 8'h5E;
    mask = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_1);
      if (cpu_ready) mask |= (1 << k);
      if (k == 5) cpu_req = 1'b0;
    end
    @(negedge clk_1);
    if (cpu_ready) mask |= (1 << 6);
    m_hc = m_hc + 16'd2; m_rdata = 8'h5E;
    chk("b2b.ready_cycles", 32'(mask), 32'h24);
    chk("b2b.hit_cnt", 32'(hit_cnt), 32'(m_hc));

    // Reset in the middle of a memory read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4444; cache_hit = 1'b0; mem_ack = 1'b0;
    @(negedge clk_1);
    cpu_req = 1'b0;
    @(negedge clk_1);
    chk("midrst.in_mem_rd", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst.mem_req_async", 32'(mem_req), 32'd0);
    chk("midrst.outs", 32'({cpu_ready, cpu_err, cache_w_rd, cache_addr}), 32'd0);
    chk("midrst.counts", {hit_cnt, miss_cnt}, 32'd0);
    w_rd_seen = 0; rdy_seen = 0;
    mem_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_1);
      if (k == 3) begin
        mem_ack = 1'b0;
        #2 rst = 1'b1;
      end
      if (cpu_ready) rdy_seen++;
      if (cache_w_rd || mem_req) w_rd_seen++;
    end
    chk("midrst.no_ready", 32'(rdy_seen), 32'd0);
    chk("midrst.no_fill_or_req", 32'(w_rd_seen), 32'd0);
    m_hc = 16'h0000; m_mc = 16'h0000; m_rdata = 8'h00;
    model(1'b0, 1'b0, 8'h00, 8'h00, 8'h6D, 0, e);
    run_access(1'b0, 16'h4444, 8'h00, 1'b0, 8'h00, 0, 8'h6D, 1'b0, o);
    verify("after_rst", o, e, 16'h4444);

    // Random accesses with spurious acks outside memory states.
    for (int i = 0; i < 120; i++) begin
      we = 1'($urandom); hit = 1'($urandom); addr = 16'($urandom);
      wd = 8'($urandom); crd = 8'($urandom); mrd = 8'($urandom);
      case ($urandom_range(0, 6))
        0, 1, 2, 3: w = int'($urandom_range(0, 3));
        4:          w = MAX_WAIT - 1;
        5:          w = MAX_WAIT;
        default:    w = -1;
      endcase
      model(we, hit, wd, crd, mrd, w, e);
      run_access(we, addr, wd, hit, crd, w, mrd, 1'b1, o);
      verify($sformatf("rnd%0d", i), o, e, addr);
    end

    // Counter saturation, starting from preloaded counts.
    @(negedge clk_1);
    force dut.hit_r = 16'hFFFE;
    force dut.miss_r = 16'hFFFF;
    #1;
    release dut.hit_r;
    release dut.miss_r;
    m_hc = 16'hFFFE; m_mc = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      model(1'b0, 1'b1, 8'h00, 8'(8'h20 + i), 8'h00, 0, e);
      run_access(1'b0, 16'h0AA0, 8'h00, 1'b1, 8'(8'h20 + i), 0, 8'h00, 1'b0, o);
      verify($sformatf("sat_hit%0d", i), o, e, 16'h0AA0);
    end
    model(1'b0, 1'b0, 8'h00, 8'h00, 8'hE1, 1, e);
    run_access(1'b0, 16'h0BB0, 8'h00, 1'b0, 8'h00, 1, 8'hE1, 1'b0, o);
    verify("sat_miss", o, e, 16'h0BB0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
